// File: rtl/ser_add_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Guarded so the package and its macro can be pulled in more than once.
`ifndef SER_ADD_PKG_SV
`define SER_ADD_PKG_SV

// Elaboration-time guard: WIDTH must be an exact multiple of DIGIT.
`define SER_ADD_CHECK_DIV(W, D) \
    if (((W) % (D)) != 0) begin : g_width_digit_check \
        $error("ser_addsub_param: WIDTH must be a multiple of DIGIT"); \
    end

package ser_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/ser_digit_add.sv
// DIGIT-bit adder slice with carry-in; also reports the carry into its top bit
// so the caller can derive two's-complement overflow on the final digit.
module ser_digit_add
    import ser_add_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] total;

    always_comb begin
        total = {1'b0, x} + {1'b0, y} + (DIGIT+1)'(cin);
        s     = total[DIGIT-1:0];
        cout  = total[DIGIT];
        // Sum bit = x ^ y ^ carry-in, so the carry into the top bit falls out directly.
        c_msb = total[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    end

endmodule

// File: rtl/ser_addsub_param.sv
// Digit-serial adder/subtractor behind a start/done handshake.
// Operands are consumed LSB digit first; results are held until the next completion.
module ser_addsub_param
    import ser_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    `SER_ADD_CHECK_DIV(WIDTH, DIGIT)

    if (WIDTH < 2) begin : g_width_min_check
        $error("ser_addsub_param: WIDTH must be at least 2");
    end

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept_c;
    logic             last_c;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;

    ser_digit_add #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (a_sh[DIGIT-1:0]),
        .y     (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .s     (dig_s),
        .cout  (dig_co),
        .c_msb (dig_cmsb)
    );

    // Handshake qualifiers and the result register after this digit lands on top.
    always_comb begin
        accept_c = start && ((state == IDLE) || (state == DONE));
        last_c   = (state == RUN) && (cnt == LAST);
        r_nx     = (r_sh >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c) state_nx = RUN;
            RUN:     if (last_c)   state_nx = DONE;
            DONE:    state_nx = accept_c ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand/result shifting, digit counter and held output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last_c;
            if (accept_c) begin
                a_sh  <= a;
                b_sh  <= b ^ {WIDTH{sub}};
                r_sh  <= '0;
                carry <= sub;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                r_sh  <= r_nx;
                carry <= dig_co;
                cnt   <= cnt + CW'(1);
                if (last_c) begin
                    sum  <= r_nx;
                    cout <= dig_co;
                    ovf  <= dig_cmsb ^ dig_co;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule
